// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one pipelined complex multiplier among NUM_REQ
// requesters. Issued operations are tagged with the requester ID in an
// in-order FIFO so each returning result can be steered back to its owner.
module cmul_arbiter #(
    parameter int unsigned FLOAT_LEN = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*2*FLOAT_LEN-1:0]   req_a,
    input  logic [NUM_REQ*2*FLOAT_LEN-1:0]   req_b,
    output logic [2*FLOAT_LEN-1:0]           mul_in1,
    output logic [2*FLOAT_LEN-1:0]           mul_in2,
    output logic                             mul_in_valid,
    input  logic [2*FLOAT_LEN-1:0]           mul_out,
    input  logic                             mul_out_valid,
    output logic [2*FLOAT_LEN-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [$clog2(TAG_DEPTH):0]       inflight,
    output logic                             err_spurious
);

    localparam int unsigned CW    = 2 * FLOAT_LEN;
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic               can_grant;
    logic               fire;
    logic               pop;
    logic               spurious;
    logic [CNT_W:0]     credit_used;
    logic [CW-1:0]      sel_a;
    logic [CW-1:0]      sel_b;

    logic [ID_W-1:0]    tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ID_W-1:0]    head_id;
    logic [NUM_REQ-1:0] head_onehot;

    // Credit check: the issue sitting in the output register already holds a tag slot.
    always_comb begin
        credit_used = {1'b0, inflight} + (CNT_W + 1)'(mul_in_valid);
        can_grant   = credit_used < (CNT_W + 1)'(TAG_DEPTH);
    end

    // Round-robin search: first pass covers rr_ptr..NUM_REQ-1, second pass wraps to the lowest index.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                found    = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        fire = can_grant && found;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // rst gates only the visible grant; all state is held in reset regardless of fire
            req_ready[i] = rst && fire && (grant_id == ID_W'(i));
        end
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*CW +: CW];
                sel_b = req_b[i*CW +: CW];
            end
        end
    end

    // Result classification and head-of-FIFO decode.
    always_comb begin
        pop      = mul_out_valid && (inflight != '0);
        spurious = mul_out_valid && (inflight == '0);
        head_id  = tag_mem[rd_ptr];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            head_onehot[i] = (head_id == ID_W'(i));
        end
    end

    // Tag storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

    // Issue registers, RR pointer, FIFO pointers/occupancy, response and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            mul_in1      <= '0;
            mul_in2      <= '0;
            mul_in_valid <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            rsp_data     <= '0;
            rsp_valid    <= '0;
            err_spurious <= 1'b0;
        end else begin
            mul_in_valid <= fire;
            if (fire) begin
                mul_in1 <= sel_a;
                mul_in2 <= sel_b;
                rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                rsp_data <= mul_out;
            end
            case ({fire, pop})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            rsp_valid <= pop ? head_onehot : '0;
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmul_arbiter.sv
// Self-checking bench for cmul_arbiter: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model and an in-bench
// multiplier model with fixed latency L.
module tb_cmul_arbiter;

    localparam int unsigned FL = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned TD = 16;
    localparam int unsigned L  = 6;
    localparam int unsigned W2 = 2 * FL;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W2-1:0]   req_a;
    logic [N*W2-1:0]   req_b;
    logic [W2-1:0]     mul_in1;
    logic [W2-1:0]     mul_in2;
    logic              mul_in_valid;
    logic [W2-1:0]     mul_out;
    logic              mul_out_valid;
    logic [W2-1:0]     rsp_data;
    logic [N-1:0]      rsp_valid;
    logic [4:0]        inflight;
    logic              err_spurious;

    cmul_arbiter #(.FLOAT_LEN(FL), .NUM_REQ(N), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_in_valid(mul_in_valid),
        .mul_out(mul_out), .mul_out_valid(mul_out_valid),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .inflight(inflight), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            m_rr;
    int            m_tags[$];
    logic          m_miv;
    logic [63:0]   m_in1, m_in2, m_rspd;
    logic [N-1:0]  m_rspv;
    logic          m_err;

    // multiplier model: in-order queue of results with their due cycle
    typedef struct { logic [63:0] d; int t; } mop_t;
    mop_t          mq[$];
    int            cyc;
    bit            stall;
    int            release_n;
    bit            spur;
    logic [N-1:0]  last_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // opaque stand-in for the complex product; 1.0+0j acts as identity
    function automatic logic [63:0] mul_fn(input logic [63:0] a, input logic [63:0] b);
        if (a == 64'h3F800000_00000000) return b;
        return a ^ {b[31:0], b[63:32]} ^ 64'h5A5A_0F0F_C3C3_9696;
    endfunction

    task automatic model_clear();
        m_rr = 0;
        m_tags.delete();
        m_miv = 1'b0;
        m_in1 = '0;
        m_in2 = '0;
        m_rspd = '0;
        m_rspv = '0;
        m_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_mul_in_valid"}, 64'(mul_in_valid), 64'd0);
        chk({tag, "_mul_in1"}, mul_in1, 64'd0);
        chk({tag, "_mul_in2"}, mul_in2, 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_inflight"}, 64'(inflight), 64'd0);
        chk({tag, "_err"}, 64'(err_spurious), 64'd0);
    endtask

    // Starts at posedge+1, ends at posedge+1 with rst released.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        req_valid = '1;
        #1;
        chk_all_zero(tag);
        req_valid = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock: drive multiplier model, check grant, advance model, check registered outputs.
    task automatic cycle();
        int w;
        logic [N-1:0] exp_ready;
        bit can;
        mop_t e;
        mul_out_valid = 1'b0;
        mul_out = {$urandom, $urandom};
        if (mq.size() > 0 && mq[0].t <= cyc && (!stall || release_n > 0)) begin
            mul_out_valid = 1'b1;
            mul_out = mq[0].d;
            void'(mq.pop_front());
            if (stall) release_n--;
        end else if (spur) begin
            mul_out_valid = 1'b1;
            mul_out = 64'hDEAD_BEEF_0BAD_F00D;
        end
        #1;
        can = (m_tags.size() + int'(m_miv)) < int'(TD);
        w = -1;
        if (can) begin
            for (int k = 0; k < int'(N); k++) begin
                int i = (m_rr + k) % int'(N);
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        // pop is judged on occupancy before this edge's push
        if (mul_out_valid && m_tags.size() > 0) begin
            m_rspv = '0;
            m_rspv[m_tags.pop_front()] = 1'b1;
            m_rspd = mul_out;
        end else begin
            m_rspv = '0;
            if (mul_out_valid) m_err = 1'b1;
        end
        m_miv = (w >= 0);
        if (w >= 0) begin
            m_in1 = req_a[w*W2 +: W2];
            m_in2 = req_b[w*W2 +: W2];
            m_tags.push_back(w);
            e.d = mul_fn(m_in1, m_in2);
            e.t = cyc + 1 + int'(L);
            mq.push_back(e);
            m_rr = (w + 1) % int'(N);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("mul_in_valid", 64'(mul_in_valid), 64'(m_miv));
        chk("mul_in1", mul_in1, m_in1);
        chk("mul_in2", mul_in2, m_in2);
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
        chk("rsp_data", rsp_data, m_rspd);
        chk("inflight", 64'(inflight), 64'(m_tags.size()));
        chk("err_spurious", 64'(err_spurious), 64'(m_err));
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < int'(N * W2 / 32); i++) begin
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic drain(input string tag);
        stall = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 100 && (mq.size() > 0 || m_tags.size() > 0); k++) cycle();
        cycle();
        chk({tag, "_drained"}, 64'(inflight), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit got;
        int grants;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        mul_out = '0;
        mul_out_valid = 1'b0;
        stall = 1'b0;
        release_n = 0;
        spur = 1'b0;
        cyc = 0;
        model_clear();
        #2;
        do_reset("reset");

        // single request from requester 0: (1+0j)*(2+0j)
        req_a[63:0] = 64'h3F800000_00000000;
        req_b[63:0] = 64'h40000000_00000000;
        req_valid = 4'b0001;
        cycle();
        chk("single_ready", 64'(last_ready), 64'h1);
        chk("single_inflight", 64'(inflight), 64'd1);
        req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (rsp_valid != '0) begin
                got = 1'b1;
                chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
                chk("single_rsp_data", rsp_data, 64'h40000000_00000000);
                chk("single_latency", 64'(k + 1), 64'(L + 1));
            end
        end
        chk("single_rsp_seen", 64'(got), 64'd1);
        chk("single_inflight_end", 64'(inflight), 64'd0);

        // all four requesters held valid: strict rotation from a fresh pointer
        do_reset("reset_rr");
        randomize_operands();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_order", 64'(last_ready), 64'(1) << (k % int'(N)));
        end
        drain("rr");

        // credit limit with the multiplier stalled
        do_reset("reset_credit");
        randomize_operands();
        stall = 1'b1;
        req_valid = '1;
        grants = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (last_ready != '0) grants++;
        end
        chk("credit_grants", 64'(grants), 64'd16);
        chk("credit_inflight", 64'(inflight), 64'd16);
        chk("credit_ready_zero", 64'(last_ready), 64'd0);
        release_n = 1;
        grants = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (last_ready != '0) grants++;
        end
        chk("credit_release_grants", 64'(grants), 64'd1);
        drain("credit");

        // steady one-per-cycle traffic: occupancy settles at L+1 with no response gaps
        randomize_operands();
        req_valid = 4'b0010;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (k >= 12) begin
                chk("steady_inflight", 64'(inflight), 64'(L + 1));
                chk("steady_rsp_valid", 64'(rsp_valid), 64'h2);
            end
        end
        drain("steady");

        // spurious result with empty FIFO, then one alongside a push into the empty FIFO
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        chk("spur_err", 64'(err_spurious), 64'd1);
        chk("spur_no_rsp", 64'(rsp_valid), 64'd0);
        cycle();
        chk("spur_err_held", 64'(err_spurious), 64'd1);
        randomize_operands();
        req_valid = 4'b0100;
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        req_valid = '0;
        chk("spur_push_inflight", 64'(inflight), 64'd1);
        drain("spur");
        chk("spur_err_final", 64'(err_spurious), 64'd1);

        // reset with five operations in flight; stale results must only raise the error
        randomize_operands();
        req_valid = '1;
        for (int k = 0; k < 5; k++) cycle();
        chk("midflight_inflight", 64'(inflight), 64'd5);
        stall = 1'b1;
        do_reset("reset_midflight");
        stall = 1'b0;
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            cycle();
            chk("stale_no_rsp", 64'(rsp_valid), 64'd0);
        end
        chk("stale_drained", 64'(mq.size()), 64'd0);
        chk("stale_err", 64'(err_spurious), 64'd1);
        chk("stale_inflight", 64'(inflight), 64'd0);

        // randomized traffic with random multiplier stalls
        do_reset("reset_random");
        for (int k = 0; k < 300; k++) begin
            req_valid = N'($urandom);
            randomize_operands();
            stall = ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
